// File: rtl/instr_fetch_buffer.sv
// Instruction fetch front end: single-outstanding request/ack fetch engine
// feeding a {pc, instr} FIFO, with redirect flush and in-flight discard.
module instr_fetch_buffer #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     start_i,
   input  logic                     redirect_i,
   input  logic [31:0]              redirect_pc_i,
   output logic                     mem_req_o,
   output logic [31:0]              mem_addr_o,
   input  logic                     mem_ack_i,
   input  logic [31:0]              mem_data_i,
   output logic                     instr_valid_o,
   output logic [31:0]              instr_o,
   output logic [31:0]              pc_o,
   output logic [31:0]              advance_pc_o,
   input  logic                     instr_ready_i,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = {1'b1, {AW{1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_REQ   = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t          state;
   logic [31:0]     fetch_pc;
   logic [AW-1:0]   rd_ptr;
   logic [AW-1:0]   wr_ptr;
   logic [31:0]     pc_mem    [DEPTH];
   logic [31:0]     instr_mem [DEPTH];

   logic            flush;
   logic            push;
   logic            pop;
   logic            room;
   logic [AW:0]     count_after_pop;
   logic [AW:0]     count_next;
   logic [AW-1:0]   rd_ptr_next;
   logic [AW-1:0]   wr_ptr_next;
   logic [31:0]     head_pc_next;
   logic [31:0]     head_instr_next;

   assign flush           = redirect_i;
   assign push            = (state == S_REQ) && mem_ack_i && !redirect_i;
   assign pop             = instr_ready_i && instr_valid_o && !flush;
   assign count_after_pop = count_o - (AW+1)'(pop);
   assign count_next      = flush ? '0 : count_after_pop + (AW+1)'(push);
   assign room            = start_i && (count_next < FULL);
   assign rd_ptr_next     = flush ? '0 : rd_ptr + AW'(pop);
   assign wr_ptr_next     = flush ? '0 : wr_ptr + AW'(push);
   assign advance_pc_o    = pc_o + 32'd4;

   // Head is registered: a push into an (after-pop) empty FIFO bypasses storage.
   always_comb begin
      head_pc_next    = pc_o;
      head_instr_next = instr_o;
      if (!flush) begin
         if (push && (count_after_pop == '0)) begin
            head_pc_next    = mem_addr_o;
            head_instr_next = mem_data_i;
         end else begin
            head_pc_next    = pc_mem[rd_ptr_next];
            head_instr_next = instr_mem[rd_ptr_next];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         pc_mem[wr_ptr]    <= mem_addr_o;
         instr_mem[wr_ptr] <= mem_data_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state         <= S_IDLE;
         fetch_pc      <= RESET_PC;
         mem_req_o     <= 1'b0;
         mem_addr_o    <= RESET_PC;
         rd_ptr        <= '0;
         wr_ptr        <= '0;
         count_o       <= '0;
         instr_valid_o <= 1'b0;
         pc_o          <= '0;
         instr_o       <= '0;
      end else begin
         rd_ptr        <= rd_ptr_next;
         wr_ptr        <= wr_ptr_next;
         count_o       <= count_next;
         instr_valid_o <= (count_next != '0);
         pc_o          <= head_pc_next;
         instr_o       <= head_instr_next;
         unique case (state)
            S_IDLE: begin
               if (redirect_i) begin
                  fetch_pc <= redirect_pc_i;
               end else if (room) begin
                  state      <= S_REQ;
                  mem_req_o  <= 1'b1;
                  mem_addr_o <= fetch_pc;
               end
            end
            S_REQ: begin
               if (mem_ack_i) begin
                  if (redirect_i) begin
                     fetch_pc  <= redirect_pc_i;
                     state     <= S_IDLE;
                     mem_req_o <= 1'b0;
                  end else begin
                     fetch_pc <= mem_addr_o + 32'd4;
                     if (room) begin
                        mem_addr_o <= mem_addr_o + 32'd4;
                     end else begin
                        state     <= S_IDLE;
                        mem_req_o <= 1'b0;
                     end
                  end
               end else if (redirect_i) begin
                  fetch_pc <= redirect_pc_i;
                  state    <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (redirect_i) begin
                  fetch_pc <= redirect_pc_i;
               end
               if (mem_ack_i) begin
                  state     <= S_IDLE;
                  mem_req_o <= 1'b0;
               end
            end
            default: begin
               state     <= S_IDLE;
               mem_req_o <= 1'b0;
            end
         endcase
      end
   end

   push_when_full: assert property (@(posedge clk_i) disable iff (!rst_i)
      !(push && (count_o == FULL)));

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Directed bench for instr_fetch_buffer: reset, streaming, backpressure,
// redirect while in flight, simultaneous flush/ack/pop, and fetch stop.
module tb_instr_fetch_buffer;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        start_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic        mem_ack_i;
   logic [31:0] mem_data_i;
   logic        instr_valid_o;
   logic [31:0] instr_o;
   logic [31:0] pc_o;
   logic [31:0] advance_pc_o;
   logic        instr_ready_i;
   logic [2:0]  count_o;

   logic        auto_ack;
   logic        man_ack;
   int          errors = 0;
   int          checks = 0;

   instr_fetch_buffer #(.DEPTH(4), .RESET_PC(32'h0)) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .start_i       (start_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .mem_req_o     (mem_req_o),
      .mem_addr_o    (mem_addr_o),
      .mem_ack_i     (mem_ack_i),
      .mem_data_i    (mem_data_i),
      .instr_valid_o (instr_valid_o),
      .instr_o       (instr_o),
      .pc_o          (pc_o),
      .advance_pc_o  (advance_pc_o),
      .instr_ready_i (instr_ready_i),
      .count_o       (count_o)
   );

   always #5 clk_i = ~clk_i;

   // Memory: zero-wait (ack follows req) or manually acked; data is addr ^ A5A5_0000.
   assign mem_ack_i  = auto_ack ? mem_req_o : man_ack;
   assign mem_data_i = mem_addr_o ^ 32'hA5A5_0000;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic nstep();
      @(negedge clk_i);
   endtask

   initial begin
      rst_i = 1'b1; start_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
      instr_ready_i = 1'b0; auto_ack = 1'b1; man_ack = 1'b0;
      #2 rst_i = 1'b0;
      #1;
      check("rst_req",   32'(mem_req_o), 32'd0);
      check("rst_addr",  mem_addr_o, 32'h0);
      check("rst_count", 32'(count_o), 32'd0);
      check("rst_valid", 32'(instr_valid_o), 32'd0);
      nstep(); nstep();

      // Sequential fetch, zero-wait memory, consumer always ready
      rst_i = 1'b1; start_i = 1'b1; instr_ready_i = 1'b1;
      nstep();
      check("seq_req",  32'(mem_req_o), 32'd1);
      check("seq_addr", mem_addr_o, 32'h0);
      nstep();
      check("seq_valid0", 32'(instr_valid_o), 32'd1);
      check("seq_pc0",    pc_o, 32'h0);
      check("seq_instr0", instr_o, 32'hA5A5_0000);
      check("seq_adv0",   advance_pc_o, 32'h4);
      nstep();
      check("seq_pc1",    pc_o, 32'h4);
      check("seq_instr1", instr_o, 32'hA5A5_0004);
      check("seq_cnt1",   32'(count_o), 32'd1);
      nstep();
      check("seq_pc2",    pc_o, 32'h8);
      nstep();
      check("seq_pc3",    pc_o, 32'hC);
      check("seq_instr3", instr_o, 32'hA5A5_000C);
      check("seq_adv3",   advance_pc_o, 32'h10);

      // Reset mid-request: outputs clear without a clock edge
      check("mid_req_pre", 32'(mem_req_o), 32'd1);
      rst_i = 1'b0;
      #1;
      check("mid_rst_req",   32'(mem_req_o), 32'd0);
      check("mid_rst_addr",  mem_addr_o, 32'h0);
      check("mid_rst_count", 32'(count_o), 32'd0);
      check("mid_rst_valid", 32'(instr_valid_o), 32'd0);
      nstep();

      // Backpressure: fill to DEPTH, request drops, one pop resumes at 16
      rst_i = 1'b1; start_i = 1'b1; instr_ready_i = 1'b0;
      nstep(); nstep(); nstep(); nstep();
      check("bp_cnt3",  32'(count_o), 32'd3);
      check("bp_req3",  32'(mem_req_o), 32'd1);
      check("bp_addr3", mem_addr_o, 32'hC);
      nstep();
      check("bp_cnt4", 32'(count_o), 32'd4);
      check("bp_req4", 32'(mem_req_o), 32'd0);
      nstep();
      check("bp_hold_req", 32'(mem_req_o), 32'd0);
      check("bp_hold_cnt", 32'(count_o), 32'd4);
      check("bp_head",     pc_o, 32'h0);
      instr_ready_i = 1'b1;
      nstep();
      instr_ready_i = 1'b0;
      check("bp_resume_req",  32'(mem_req_o), 32'd1);
      check("bp_resume_addr", mem_addr_o, 32'h10);
      check("bp_pop_cnt",     32'(count_o), 32'd3);
      check("bp_pop_head",    pc_o, 32'h4);

      // Redirect while a slow fetch is in flight
      rst_i = 1'b0;
      #1;
      auto_ack = 1'b0; man_ack = 1'b0;
      nstep();
      rst_i = 1'b1; start_i = 1'b1; instr_ready_i = 1'b0;
      nstep();
      check("rd_req",  32'(mem_req_o), 32'd1);
      check("rd_addr", mem_addr_o, 32'h0);
      redirect_i = 1'b1; redirect_pc_i = 32'h100;
      nstep();
      redirect_i = 1'b0;
      check("rd_hold_req",  32'(mem_req_o), 32'd1);
      check("rd_hold_addr", mem_addr_o, 32'h0);
      check("rd_cnt_a",     32'(count_o), 32'd0);
      nstep();
      check("rd_hold2_addr", mem_addr_o, 32'h0);
      man_ack = 1'b1;
      nstep();
      man_ack = 1'b0;
      check("rd_drop_cnt",   32'(count_o), 32'd0);
      check("rd_drop_valid", 32'(instr_valid_o), 32'd0);
      check("rd_drop_req",   32'(mem_req_o), 32'd0);
      nstep();
      check("rd_new_req",  32'(mem_req_o), 32'd1);
      check("rd_new_addr", mem_addr_o, 32'h100);
      check("rd_new_cnt",  32'(count_o), 32'd0);
      man_ack = 1'b1;
      nstep();
      check("rd_push_cnt",   32'(count_o), 32'd1);
      check("rd_push_pc",    pc_o, 32'h100);
      check("rd_push_instr", instr_o, 32'hA5A5_0100);

      // Redirect, ack and pop together with two entries queued
      nstep();
      check("sim_cnt2", 32'(count_o), 32'd2);
      redirect_i = 1'b1; redirect_pc_i = 32'h100; instr_ready_i = 1'b1;
      nstep();
      redirect_i = 1'b0; instr_ready_i = 1'b0; man_ack = 1'b0;
      check("sim_cnt",   32'(count_o), 32'd0);
      check("sim_valid", 32'(instr_valid_o), 32'd0);
      check("sim_req",   32'(mem_req_o), 32'd0);
      nstep();
      check("sim_new_addr", mem_addr_o, 32'h100);
      man_ack = 1'b1;
      nstep();
      man_ack = 1'b0;
      check("sim_pc",  pc_o, 32'h100);
      check("sim_cnt1", 32'(count_o), 32'd1);

      // Stop: pending request completes and is pushed, then nothing more
      start_i = 1'b0;
      nstep();
      check("stop_pending_req",  32'(mem_req_o), 32'd1);
      check("stop_pending_addr", mem_addr_o, 32'h104);
      man_ack = 1'b1;
      nstep();
      man_ack = 1'b1;
      check("stop_req",   32'(mem_req_o), 32'd0);
      check("stop_cnt",   32'(count_o), 32'd2);
      nstep();
      man_ack = 1'b0;
      check("stop_stray_ack_cnt", 32'(count_o), 32'd2);
      nstep();
      check("stop_idle_req", 32'(mem_req_o), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
